// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - multi-channel LED controller with shared prescaler, PWM and blink timing
module led_ctrl #(
   parameter int CHANNELS   = 8,
   parameter int PWM_BITS   = 4,
   parameter int BLINK_BITS = 3
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                WE,
   input  logic [4:0]          ADDR,
   input  logic [7:0]          WD,
   output logic [7:0]          RD,
   output logic [CHANNELS-1:0] LEDS
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_PWM   = 2'b10,
      MODE_BLINK = 2'b11
   } mode_t;

   mode_t                 mode   [CHANNELS];
   logic [PWM_BITS-1:0]   shadow [CHANNELS];
   logic [PWM_BITS-1:0]   active [CHANNELS];
   logic [7:0]            div_q;
   logic [7:0]            presc;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic                  tick;
   logic                  wrap;
   logic                  div_wr;
   logic                  blink_phase;
   logic [CHANNELS-1:0]   cfg_wr;
   logic [CHANNELS-1:0]   pwm_on;
   logic [CHANNELS-1:0]   leds_d;
   logic                  unused_wd;

   assign tick        = (presc == div_q);
   assign wrap        = tick && (pwm_cnt == '1);
   assign div_wr      = WE && ADDR[4];
   assign blink_phase = blink_cnt[BLINK_BITS-1];
   assign unused_wd   = ^WD;

   always_comb begin
      cfg_wr = '0;
      pwm_on = '0;
      leds_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cfg_wr[i] = WE && !ADDR[4] && (ADDR[3:0] == 4'(i));
         pwm_on[i] = (pwm_cnt < active[i]);
         case (mode[i])
            MODE_ON:    leds_d[i] = 1'b1;
            MODE_PWM:   leds_d[i] = pwm_on[i];
            MODE_BLINK: leds_d[i] = pwm_on[i] & blink_phase;
            default:    leds_d[i] = 1'b0;
         endcase
      end
   end

   // Out-of-range channel addresses match no entry, so they read 0 and drop writes.
   always_comb begin
      RD = '0;
      if (ADDR[4]) begin
         RD = div_q;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (ADDR[3:0] == 4'(i)) begin
               RD[7:6]          = mode[i];
               RD[PWM_BITS-1:0] = shadow[i];
            end
         end
      end
   end

   // Active duty only follows the shadow at a PWM wrap so a period is never cut short.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < CHANNELS; i++) begin
            mode[i]   <= MODE_OFF;
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_wr[i]) begin
               mode[i]   <= mode_t'(WD[7:6]);
               shadow[i] <= WD[PWM_BITS-1:0];
            end
            if (wrap) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         div_q     <= '0;
         presc     <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         LEDS      <= '0;
      end else begin
         if (div_wr) begin
            div_q <= WD;
         end
         if (div_wr || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + 8'd1;
         end
         if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         end
         if (wrap) begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
         end
         LEDS <= leds_d;
      end
   end

endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - self-checking bench for led_ctrl with a cycle-count based reference model
module tb_led_ctrl;
   localparam int CH = 8;
   localparam int PB = 4;
   localparam int BB = 3;
   localparam int PERIOD = 1 << PB;
   localparam int BLINKS = 1 << BB;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          WE = 1'b0;
   logic [4:0]    ADDR = '0;
   logic [7:0]    WD = '0;
   logic [7:0]    RD;
   logic [CH-1:0] LEDS;

   int checks = 0;
   int failures = 0;

   led_ctrl #(.CHANNELS(CH), .PWM_BITS(PB), .BLINK_BITS(BB)) dut (
      .CLK(CLK), .RESET(RESET), .WE(WE), .ADDR(ADDR), .WD(WD), .RD(RD), .LEDS(LEDS)
   );

   always #5 CLK = ~CLK;

   // Model state: timing is derived from total ticks and cycles since the last prescaler clear.
   int            m_mode   [CH];
   int            m_shadow [CH];
   int            m_active [CH];
   int            m_div;
   int            m_cyc;
   int            m_ticks;
   int            m_pos;
   bit            m_tick;
   bit            m_wrap;
   bit            m_phase;
   logic [CH-1:0] m_leds;

   initial forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) begin
         for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0; m_shadow[i] = 0; m_active[i] = 0;
         end
         m_div = 0; m_cyc = 0; m_ticks = 0; m_leds = '0;
      end else begin
         m_tick  = (m_cyc % (m_div + 1)) == m_div;
         m_pos   = m_ticks % PERIOD;
         m_wrap  = m_tick && (m_pos == PERIOD - 1);
         m_phase = ((m_ticks / PERIOD) % BLINKS) >= (BLINKS / 2);
         for (int i = 0; i < CH; i++) begin
            case (m_mode[i])
               1:       m_leds[i] = 1'b1;
               2:       m_leds[i] = (m_pos < m_active[i]);
               3:       m_leds[i] = (m_pos < m_active[i]) && m_phase;
               default: m_leds[i] = 1'b0;
            endcase
            if (m_wrap) m_active[i] = m_shadow[i];
         end
         if (m_tick) m_ticks++;
         if (WE && ADDR[4]) begin
            m_div = int'(WD);
            m_cyc = 0;
         end else begin
            m_cyc++;
         end
         if (WE && !ADDR[4] && int'(ADDR[3:0]) < CH) begin
            m_mode[int'(ADDR[3:0])]   = int'(WD[7:6]);
            m_shadow[int'(ADDR[3:0])] = int'(WD[PB-1:0]);
         end
      end
   end

   function automatic logic [7:0] exp_rd(input logic [4:0] a);
      int idx;
      idx = int'(a[3:0]);
      if (a[4]) return 8'(m_div);
      if (idx < CH) return {2'(m_mode[idx]), 6'(m_shadow[idx])};
      return 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      #2;
      check("leds_model", 32'(LEDS), 32'(m_leds));
      check("rd_model", 32'(RD), 32'(exp_rd(ADDR)));
   end

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge CLK);
      WE = 1'b1; ADDR = a; WD = d;
      @(negedge CLK);
      WE = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
      @(negedge CLK);
      WE = 1'b0; ADDR = a;
      #2;
      check(name, 32'(RD), 32'(exp));
   endtask

   task automatic count_high(input int ch, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge CLK);
         #2;
         cnt += int'(LEDS[ch]);
      end
   endtask

   int cnt;
   bit found;

   initial begin
      repeat (2) @(negedge CLK);
      check("reset_leds", 32'(LEDS), 32'h0);
      RESET = 1'b1;
      for (int a = 0; a < 8; a++) rd_check("reset_rd", 5'(a), 8'h00);
      rd_check("reset_rd_div", 5'd16, 8'h00);
      wr(5'd9, 8'h40);
      rd_check("oob_rd", 5'd9, 8'h00);
      repeat (2) @(posedge CLK);
      #2 check("oob_leds", 32'(LEDS), 32'h0);

      wr(5'd0, 8'h40);
      check("on_not_yet", 32'(LEDS), 32'h00);
      @(posedge CLK); #2;
      check("on_leds", 32'(LEDS), 32'h01);
      wr(5'd0, 8'h00);
      @(posedge CLK); #2;
      check("off_leds", 32'(LEDS), 32'h00);

      wr(5'd16, 8'h00);
      wr(5'd1, 8'h84);
      rd_check("pwm_rd", 5'd1, 8'h84);
      repeat (20) @(posedge CLK);
      count_high(1, 16, cnt);
      check("pwm_high16", 32'(cnt), 32'd4);
      count_high(1, 32, cnt);
      check("pwm_high32", 32'(cnt), 32'd8);

      wr(5'd16, 8'h03);
      rd_check("div_rd", 5'd16, 8'h03);
      repeat (70) @(posedge CLK);
      count_high(1, 64, cnt);
      check("pwm_div_high64", 32'(cnt), 32'd16);

      wr(5'd16, 8'h00);
      wr(5'd2, 8'hC8);
      rd_check("blink_rd", 5'd2, 8'hC8);
      repeat (20) @(posedge CLK);
      count_high(2, 128, cnt);
      check("blink_high128", 32'(cnt), 32'd32);

      wr(5'd1, 8'h8C);
      rd_check("shadow_rd", 5'd1, 8'h8C);
      repeat (20) @(posedge CLK);
      count_high(1, 16, cnt);
      check("shadow_high16", 32'(cnt), 32'd12);

      found = 1'b0;
      for (int k = 0; k < 32 && !found; k++) begin
         @(posedge CLK); #2;
         if (LEDS[1]) found = 1'b1;
      end
      check("pulse_seen", 32'(found), 32'd1);
      #1 RESET = 1'b0;
      #1 check("async_reset_leds", 32'(LEDS), 32'h0);
      for (int a = 0; a < 8; a++) rd_check("reset2_rd", 5'(a), 8'h00);
      rd_check("reset2_rd_div", 5'd16, 8'h00);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (4) @(posedge CLK);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
